// File: rtl/pacessor_pkg.sv
// Shared definitions for the run-control / program-load sequencer and its program memory.
package pacessor_pkg;

    localparam int ADDR_W = 6;
    localparam int INST_W = 32;
    localparam logic [7:0] BR_OPCODE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_BOOT = 3'd2,
        ST_RUN  = 3'd3,
        ST_HALT = 3'd4,
        ST_STEP = 3'd5
    } seq_state_e;

    // Unconditional branch to the current fetch address: the PC holds and nothing is written back.
    function automatic logic [INST_W-1:0] branch_to_self(input logic [ADDR_W-1:0] pc);
        return {BR_OPCODE, 2'b00, pc, 16'h0000};
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Byte-wide program memory: one synchronous write port and a 4-byte wrapping combinational read port.
module prog_ram
    import pacessor_pkg::*;
#(
    parameter int MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    logic [7:0]        mem_r [MEM_DEPTH];
    logic [ADDR_W-1:0] raddr1_s;
    logic [ADDR_W-1:0] raddr2_s;
    logic [ADDR_W-1:0] raddr3_s;

    // Byte write; contents are deliberately not reset so a reboot can rerun the last program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Big-endian word fetch; the address adds wrap naturally in ADDR_W bits.
    always_comb begin
        raddr1_s = raddr + ADDR_W'(1);
        raddr2_s = raddr + ADDR_W'(2);
        raddr3_s = raddr + ADDR_W'(3);
        rdata    = {mem_r[raddr], mem_r[raddr1_s], mem_r[raddr2_s], mem_r[raddr3_s]};
    end

endmodule

// File: rtl/prog_sequencer.sv
// Run-control and program-load controller: loads program memory from a byte stream, sequences core
// reset, and implements halt/single-step by injecting a branch-to-self instead of gating the clock.
module prog_sequencer
    import pacessor_pkg::*;
#(
    parameter int MEM_DEPTH    = 64,
    parameter int BOOT_RST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_master_n,
    input  logic              ld_start,
    input  logic [6:0]        ld_len,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] add_o,
    output logic [INST_W-1:0] inst,
    output logic              core_rst,
    output logic [2:0]        state_o
);

    localparam int BC_W = $clog2(BOOT_RST_CYC + 1);

    seq_state_e        state_r;
    seq_state_e        next_state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] len_m1_r;
    logic [BC_W-1:0]   boot_cnt_r;
    logic              core_rst_r;
    logic              ld_ready_r;
    logic              wr_en_s;
    logic              load_done_s;
    logic              boot_done_s;
    logic [INST_W-1:0] ram_word_s;

    // A byte arriving alongside ld_start is dropped: the restart takes precedence.
    assign wr_en_s     = (state_r == ST_LOAD) && ld_valid && ld_ready_r && !ld_start;
    assign load_done_s = wr_en_s && (cnt_r == len_m1_r);
    assign boot_done_s = (state_r == ST_BOOT) && (boot_cnt_r == BC_W'(BOOT_RST_CYC - 1));

    // Next-state selection; ld_start overrides every state.
    always_comb begin
        next_state_s = state_r;
        if (ld_start) begin
            next_state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = run ? ST_BOOT : ST_IDLE;
                ST_LOAD: next_state_s = load_done_s ? ST_BOOT : ST_LOAD;
                ST_BOOT: begin
                    if (boot_done_s) begin
                        next_state_s = run ? ST_RUN : ST_HALT;
                    end else begin
                        next_state_s = ST_BOOT;
                    end
                end
                ST_RUN:  next_state_s = run ? ST_RUN : ST_HALT;
                ST_HALT: begin
                    if (run) begin
                        next_state_s = ST_RUN;
                    end else if (step) begin
                        next_state_s = ST_STEP;
                    end else begin
                        next_state_s = ST_HALT;
                    end
                end
                ST_STEP: next_state_s = ST_HALT;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered control outputs (decoded from the next state so they align with it).
    always_ff @(posedge clk or negedge rst_master_n) begin
        if (!rst_master_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {ADDR_W{1'b0}};
            len_m1_r   <= {ADDR_W{1'b0}};
            boot_cnt_r <= {BC_W{1'b0}};
            core_rst_r <= 1'b1;
            ld_ready_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            core_rst_r <= !((next_state_s == ST_RUN) || (next_state_s == ST_HALT) ||
                            (next_state_s == ST_STEP));
            ld_ready_r <= (next_state_s == ST_LOAD);
            // ld_len of 0 truncates to a last index of 63, i.e. a full 64-byte load.
            if (ld_start) begin
                cnt_r    <= {ADDR_W{1'b0}};
                len_m1_r <= ADDR_W'(ld_len - 7'd1);
            end else if (load_done_s) begin
                cnt_r    <= {ADDR_W{1'b0}};
                len_m1_r <= len_m1_r;
            end else if (wr_en_s) begin
                cnt_r    <= cnt_r + ADDR_W'(1);
                len_m1_r <= len_m1_r;
            end else begin
                cnt_r    <= cnt_r;
                len_m1_r <= len_m1_r;
            end
            if ((state_r == ST_BOOT) && !boot_done_s && !ld_start) begin
                boot_cnt_r <= boot_cnt_r + BC_W'(1);
            end else begin
                boot_cnt_r <= {BC_W{1'b0}};
            end
        end
    end

    prog_ram #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (cnt_r),
        .wdata (ld_data),
        .raddr (add_o),
        .rdata (ram_word_s)
    );

    // Instruction mux: the real fetch path is combinational from add_o so the core sees no extra latency.
    always_comb begin
        case (state_r)
            ST_RUN, ST_STEP: inst = ram_word_s;
            ST_HALT:         inst = branch_to_self(add_o);
            default:         inst = {INST_W{1'b0}};
        endcase
    end

    assign ld_ready = ld_ready_r;
    assign core_rst = core_rst_r;
    assign state_o  = state_r;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: random program bytes and fetch addresses checked against
// a byte-array memory model and the documented state/output behaviour.
module tb_prog_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_BOOT = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;
    localparam logic [2:0] S_STEP = 3'd5;

    logic        clk = 1'b0;
    logic        rst_master_n;
    logic        ld_start;
    logic [6:0]  ld_len;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        run;
    logic        step;
    logic [5:0]  add_o;
    logic [31:0] inst;
    logic        core_rst;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] ref_mem  [64];
    logic [7:0] load_buf [64];

    always #5 clk = ~clk;

    prog_sequencer dut (
        .clk          (clk),
        .rst_master_n (rst_master_n),
        .ld_start     (ld_start),
        .ld_len       (ld_len),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .run          (run),
        .step         (step),
        .add_o        (add_o),
        .inst         (inst),
        .core_rst     (core_rst),
        .state_o      (state_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        return {ref_mem[a % 64], ref_mem[(a + 1) % 64], ref_mem[(a + 2) % 64], ref_mem[(a + 3) % 64]};
    endfunction

    function automatic logic [31:0] exp_halt(input logic [5:0] a);
        return {8'h20, 2'b00, a, 16'h0000};
    endfunction

    task automatic fill_random;
        for (int i = 0; i < 64; i++) load_buf[i] = 8'($urandom);
    endtask

    task automatic boot_to(input logic [2:0] final_st);
        chk("boot1_state", 32'(state_o), 32'(S_BOOT));
        chk("boot1_core_rst", 32'(core_rst), 32'd1);
        chk("boot1_ld_ready", 32'(ld_ready), 32'd0);
        tick;
        chk("boot2_state", 32'(state_o), 32'(S_BOOT));
        chk("boot2_core_rst", 32'(core_rst), 32'd1);
        tick;
        chk("post_boot_state", 32'(state_o), 32'(final_st));
        chk("post_boot_core_rst", 32'(core_rst), 32'd0);
    endtask

    task automatic do_load(input int len, input bit gaps, input logic [2:0] final_st);
        int n;
        int acc;
        int cyc;
        int rdy;
        n   = (len == 0) ? 64 : len;
        acc = 0;
        cyc = 0;
        rdy = 0;
        ld_start = 1'b1;
        ld_len   = 7'(len);
        tick;
        ld_start = 1'b0;
        chk("load_entry_state", 32'(state_o), 32'(S_LOAD));
        chk("load_entry_core_rst", 32'(core_rst), 32'd1);
        while (acc < n && cyc < 300) begin
            ld_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            ld_data  = load_buf[acc];
            if (ld_ready) rdy++;
            if (ld_valid && ld_ready) begin
                ref_mem[acc] = ld_data;
                acc++;
            end
            tick;
            cyc++;
            if (acc < n) chk("load_hold_state", 32'(state_o), 32'(S_LOAD));
        end
        ld_valid = 1'b0;
        chk("load_cycles", 32'(cyc), gaps ? 32'(2 * n - 1) : 32'(n));
        chk("ld_ready_cycles", 32'(rdy), 32'(cyc));
        boot_to(final_st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_master_n = 1'b0;
        ld_start = 1'b0;
        ld_len   = 7'd0;
        ld_data  = 8'h00;
        ld_valid = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        add_o    = 6'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_inst", inst, 32'h0);
        rst_master_n = 1'b1;
        tick;
        chk("idle_hold", 32'(state_o), 32'(S_IDLE));
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("idle_step_ignored", 32'(state_o), 32'(S_IDLE));
        chk("idle_inst", inst, 32'h0);

        // Full 64-byte load with wrap markers, booting into HALT.
        fill_random;
        load_buf[62] = 8'hAA;
        load_buf[63] = 8'hBB;
        load_buf[0]  = 8'hCC;
        load_buf[1]  = 8'hDD;
        do_load(0, 1'b0, S_HALT);
        for (int i = 0; i < 4; i++) begin
            add_o = 6'($urandom_range(0, 63));
            #1;
            chk("halt_inst_rand", inst, exp_halt(add_o));
        end
        run = 1'b1;
        tick;
        chk("halt_to_run", 32'(state_o), 32'(S_RUN));
        add_o = 6'd62;
        #1;
        chk("wrap_inst_const", inst, 32'hAABBCCDD);
        for (int i = 0; i < 6; i++) begin
            add_o = 6'($urandom_range(0, 63));
            #1;
            chk("run_inst_rand", inst, exp_word(int'(add_o)));
        end
        ld_valid = 1'b1;
        ld_data  = ~ref_mem[0];
        step     = 1'b1;
        tick;
        tick;
        ld_valid = 1'b0;
        step     = 1'b0;
        chk("run_step_ignored", 32'(state_o), 32'(S_RUN));
        add_o = 6'd0;
        #1;
        chk("valid_outside_load_ignored", inst, exp_word(0));

        // Abort from RUN with the 8-byte program.
        load_buf[0] = 8'h10; load_buf[1] = 8'h00; load_buf[2] = 8'h05; load_buf[3] = 8'h00;
        load_buf[4] = 8'h1f; load_buf[5] = 8'h00; load_buf[6] = 8'h00; load_buf[7] = 8'h00;
        do_load(8, 1'b0, S_RUN);
        add_o = 6'd0;
        #1;
        chk("prog8_word0", inst, 32'h10000500);
        add_o = 6'd4;
        #1;
        chk("prog8_word4", inst, 32'h1f000000);
        for (int i = 0; i < 4; i++) begin
            add_o = 6'($urandom_range(5, 63));
            #1;
            chk("prog8_untouched", inst, exp_word(int'(add_o)));
        end

        // Gapped 4-byte load overwrites bytes 0..3 only.
        fill_random;
        do_load(4, 1'b1, S_RUN);
        add_o = 6'd0;
        #1;
        chk("gap_word0", inst, exp_word(0));
        add_o = 6'd4;
        #1;
        chk("gap_word4_kept", inst, 32'h1f000000);

        // Halt and single-step.
        run   = 1'b0;
        add_o = 6'd8;
        tick;
        chk("halt_state", 32'(state_o), 32'(S_HALT));
        chk("halt_inst_8", inst, 32'h20080000);
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step_state", 32'(state_o), 32'(S_STEP));
        chk("step_core_rst", 32'(core_rst), 32'd0);
        chk("step_inst", inst, exp_word(8));
        tick;
        add_o = 6'd12;
        #1;
        chk("step_back_halt", 32'(state_o), 32'(S_HALT));
        chk("step_back_inst", inst, exp_halt(6'd12));
        run  = 1'b1;
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("run_beats_step", 32'(state_o), 32'(S_RUN));

        // Asynchronous reset part-way through a load.
        fill_random;
        ld_start = 1'b1;
        ld_len   = 7'd8;
        tick;
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data    = load_buf[i];
            ref_mem[i] = load_buf[i];
            tick;
        end
        #2;
        rst_master_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state_o), 32'(S_IDLE));
        chk("async_rst_core_rst", 32'(core_rst), 32'd1);
        chk("async_rst_ld_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b0;
        run      = 1'b0;
        tick;
        rst_master_n = 1'b1;
        tick;
        chk("post_rst_idle", 32'(state_o), 32'(S_IDLE));
        run = 1'b1;
        tick;
        boot_to(S_RUN);
        add_o = 6'd0;
        #1;
        chk("partial_word0", inst, exp_word(0));
        for (int i = 0; i < 4; i++) begin
            add_o = 6'($urandom_range(0, 63));
            #1;
            chk("reboot_inst_rand", inst, exp_word(int'(add_o)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
